// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Optional parity framing is enabled by defining MMIO_UART_TX_PARITY_EN.
package uart_types;

    // Transmit FSM states; PARITY exists only in the parity-enabled build.
`ifdef MMIO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } uart_tx_state_t;
`endif

    // Register offsets inside the 16-byte window.
    localparam logic [3:0] UART_TXDATA_OFF = 4'h0;
    localparam logic [3:0] UART_STATUS_OFF = 4'h4;

    // STATUS register bit positions.
    localparam int STAT_FULL_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_BUSY_BIT   = 2;
    localparam int STAT_OVF_BIT    = 3;
    localparam int STAT_COUNT_LSB  = 4;
    localparam int STAT_COUNT_MSB  = 8;
    localparam int STAT_PARITY_BIT = 9;

    // Even parity of a byte: XOR of all eight bits.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Reusable synchronous FIFO with registered occupancy count.
// Head entry is visible combinationally so a consumer can pop and capture
// on the same edge. DEPTH must be a power of two so pointers wrap freely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_pop;
    logic             do_push;

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign do_pop   = pop && (count_q != '0);
    assign do_push  = push && ((count_q != CNT_MAX) || do_pop);
    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO fed by cpu byte writes, serialised
// as 8N1 (or 8E1 when MMIO_UART_TX_PARITY_EN is defined), with a STATUS
// register readable through the combinational rd_data/sel mux interface.
module mmio_uart_tx
    import uart_types::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_F000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write,
    input  logic [3:0]  memory_byte_enable,
    input  logic        memory_we,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        uart_tx,
    output logic        busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

    logic [3:0]        offset;
    logic              txdata_wr;
    logic              status_wr;
    logic              ovf_set;
    logic              ovf_clear;
    logic              ovf_q;

    logic              fifo_pop;
    logic [7:0]        fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;

    uart_tx_state_t    state_q;
    logic [CNT_W-1:0]  baud_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic              tx_q;
    logic              baud_last;
`ifdef MMIO_UART_TX_PARITY_EN
    logic              parity_q;
`endif

    // Upper write lanes are architecturally ignored.
    logic              unused_bits;
    assign unused_bits = ^{memory_write[31:8], memory_byte_enable[3:1]};

    assign offset    = memory_address[3:0];
    assign sel       = (memory_address[31:4] == BASE_ADDR[31:4]);
    assign txdata_wr = memory_we && sel && (offset == UART_TXDATA_OFF) && memory_byte_enable[0];
    assign status_wr = memory_we && sel && (offset == UART_STATUS_OFF) && memory_byte_enable[0];
    assign ovf_clear = status_wr && memory_write[3];
    assign baud_last = (baud_q == BAUD_LAST);

    // The FSM takes the head when idle, or at the last stop cycle so frames abut.
    assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last));
    assign ovf_set   = txdata_wr && fifo_full && !fifo_pop;

    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign uart_tx   = tx_q;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (txdata_wr),
        .push_data (memory_write[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky overflow flag; a dropped push beats a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (ovf_set) begin
            ovf_q <= 1'b1;
        end else if (ovf_clear) begin
            ovf_q <= 1'b0;
        end
    end

    // STATUS read mux; every other offset and out-of-window access reads zero.
    always_comb begin
        rd_data = '0;
        if (sel && (offset == UART_STATUS_OFF)) begin
            rd_data[STAT_FULL_BIT]                    = fifo_full;
            rd_data[STAT_EMPTY_BIT]                   = fifo_empty;
            rd_data[STAT_BUSY_BIT]                    = busy;
            rd_data[STAT_OVF_BIT]                     = ovf_q;
            rd_data[STAT_COUNT_MSB:STAT_COUNT_LSB]    = 5'(fifo_count);
`ifdef MMIO_UART_TX_PARITY_EN
            rd_data[STAT_PARITY_BIT]                  = 1'b1;
`endif
        end
    end

    // Framing FSM with registered line output; a pop overrides the state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
`ifdef MMIO_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q <= baud_q + BAUD_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
            if (fifo_pop) begin
                state_q  <= ST_START;
                baud_q   <= '0;
                shift_q  <= fifo_rd_data;
                tx_q     <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
                parity_q <= even_parity(fifo_rd_data);
`endif
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-timeline reference model
// checked every cycle, a line decoder, and literal directed expectations.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'hFFFF_F000;
    localparam int C = 4;
    localparam int D = 8;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam int          NB       = 11;
    localparam logic [31:0] STAT_PAR = 32'h200;
    localparam logic [10:0] LIT55    = 11'b10010101010;
`else
    localparam int          NB       = 10;
    localparam logic [31:0] STAT_PAR = 32'h0;
    localparam logic [10:0] LIT55    = 11'b01010101010;
`endif
    localparam int FL = NB * C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] memory_address = '0;
    logic [31:0] memory_write = '0;
    logic [3:0]  memory_byte_enable = '0;
    logic        memory_we = 1'b0;
    logic        sel;
    logic [31:0] rd_data;
    logic        uart_tx;
    logic        busy;

    int checks = 0;
    int failures = 0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .memory_address     (memory_address),
        .memory_write       (memory_write),
        .memory_byte_enable (memory_byte_enable),
        .memory_we          (memory_we),
        .sel                (sel),
        .rd_data            (rd_data),
        .uart_tx            (uart_tx),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: byte queue + frame timeline ----------
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_start = 0;
    logic [7:0] m_byte = '0;
    bit         m_ovf = 1'b0;
    int         edge_cnt = 0;

    function automatic bit in_win(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit do_pop;
        bit push_req;
        bit clr;
        int pre;
        if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            edge_cnt++;
            if (m_active && (edge_cnt - m_start == FL)) m_active = 1'b0;
            pre    = m_q.size();
            do_pop = !m_active && (pre > 0);
            if (do_pop) begin
                m_byte   = m_q.pop_front();
                m_active = 1'b1;
                m_start  = edge_cnt;
            end
            push_req = memory_we && in_win(memory_address) && (memory_address[3:0] == 4'h0)
                       && memory_byte_enable[0];
            clr      = memory_we && in_win(memory_address) && (memory_address[3:0] == 4'h4)
                       && memory_byte_enable[0] && memory_write[3];
            if (push_req && (pre < D || do_pop)) m_q.push_back(memory_write[7:0]);
            if (push_req && !(pre < D || do_pop)) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = (edge_cnt - m_start) / C;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
`ifdef MMIO_UART_TX_PARITY_EN
        if (idx == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return (m_q.size() != 0) || m_active;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = STAT_PAR;
        s[0]   = (m_q.size() == D);
        s[1]   = (m_q.size() == 0);
        s[2]   = exp_busy();
        s[3]   = m_ovf;
        s[8:4] = 5'(m_q.size());
        return s;
    endfunction

    // One compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        exp_rd = (in_win(memory_address) && memory_address[3:0] == 4'h4) ? exp_status() : 32'h0;
        check("cyc_uart_tx", 32'(uart_tx), 32'(exp_tx()));
        check("cyc_busy", 32'(busy), 32'(exp_busy()));
        check("cyc_sel", 32'(sel), 32'(in_win(memory_address)));
        check("cyc_rd_data", rd_data, exp_rd);
    end

    // ---------------- line decoder (mid-bit sampling) ----------------------
    logic [7:0] dec_q[$];
    bit         dec_on = 1'b0;
    int         dec_t = 0;
    logic [7:0] dec_byte = '0;

    always @(negedge clk or negedge rst_n) begin
        int idx;
        if (!rst_n) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (uart_tx == 1'b0) begin
                dec_on = 1'b1;
                dec_t  = 0;
            end
        end else begin
            dec_t++;
            if (dec_t % C == C / 2) begin
                idx = dec_t / C;
                if (idx >= 1 && idx <= 8) dec_byte[idx-1] = uart_tx;
                if (idx == NB - 1) begin
                    dec_q.push_back(dec_byte);
                    dec_on = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        memory_address     = a;
        memory_write       = d;
        memory_byte_enable = be;
        memory_we          = 1'b1;
        @(posedge clk);
        #1;
        memory_we          = 1'b0;
        memory_byte_enable = '0;
        $display("wr addr=0x%08h data=0x%08h be=%b edge=%0d", a, d, be, edge_cnt);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_status(output logic [31:0] v);
        memory_address = BASE + 32'h4;
        #1;
        v = rd_data;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || m_active || m_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_within_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        int k;

        // Reset asserted between clock edges: outputs must settle without clk.
        #1 rst_n = 1'b0;
        #2;
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        rd_status(v);
        check("reset_status", v, 32'h2 | STAT_PAR);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single 0x55 frame: start low on the edge after capture, LSB first.
        wr(BASE, 32'h55, 4'b0001);
        k = edge_cnt;
        for (int i = 0; i < NB; i++) begin
            wait_edge(k + 1 + i * C);
            check($sformatf("frame55_period%0d", i), 32'(uart_tx), 32'(LIT55[i]));
        end
        wait_edge(k + FL);
        check("frame55_busy_last_stop", 32'(busy), 32'd1);
        wait_edge(k + FL + 1);
        check("frame55_busy_fall", 32'(busy), 32'd0);
        idle(3);

        // Back-to-back frames decode in order.
        dec_q.delete();
        wr(BASE, 32'hA3, 4'b0001);
        wr(BASE, 32'h0F, 4'b0001);
        wait_idle(3 * FL);
        check("b2b_count", 32'(dec_q.size()), 32'd2);
        if (dec_q.size() >= 2) begin
            check("b2b_byte0", 32'(dec_q[0]), 32'hA3);
            check("b2b_byte1", 32'(dec_q[1]), 32'h0F);
        end

        // Fill past depth while the first frame is on the line.
        for (int i = 0; i < 10; i++) wr(BASE, 32'hC0 + 32'(i), 4'b0001);
        rd_status(v);
        check("ovf_status", v, 32'h8D | STAT_PAR);
        wr(BASE + 32'h4, 32'h8, 4'b0001);
        rd_status(v);
        check("ovf_cleared_status", v, 32'h85 | STAT_PAR);
        wait_idle(12 * FL);

        // Writes that must not push.
        wr(BASE, 32'h77, 4'b0010);
        wr(BASE + 32'h8, 32'h41, 4'b0001);
        rd_status(v);
        check("nopush_status", v, 32'h2 | STAT_PAR);
        check("nopush_line", 32'(uart_tx), 32'd1);
        idle(4);
        check("nopush_line_later", 32'(uart_tx), 32'd1);

        // Reset in the middle of data bit 3 of 0xF0 with more bytes queued.
        wr(BASE, 32'hF0, 4'b0001);
        k = edge_cnt;
        wr(BASE, 32'h12, 4'b0001);
        wr(BASE, 32'h34, 4'b0001);
        wait_edge(k + 1 + 4 * C + 1);
        check("pre_reset_bit3", 32'(uart_tx), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midframe_reset_line", 32'(uart_tx), 32'd1);
        check("midframe_reset_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_status(v);
        check("post_reset_status", v, 32'h2 | STAT_PAR);
        idle(5);
        check("post_reset_line", 32'(uart_tx), 32'd1);

`ifdef MMIO_UART_TX_PARITY_EN
        // Parity of 0x07 is 1; frame is one bit longer.
        wr(BASE, 32'h07, 4'b0001);
        k = edge_cnt;
        rd_status(v);
        check("parity_status_bit9", 32'(v[9]), 32'd1);
        wait_edge(k + 1 + 9 * C);
        check("parity_bit", 32'(uart_tx), 32'd1);
        wait_edge(k + FL);
        check("parity_busy_last_stop", 32'(busy), 32'd1);
        wait_edge(k + FL + 1);
        check("parity_busy_fall", 32'(busy), 32'd0);
`else
        rd_status(v);
        check("noparity_status_bit9", 32'(v[9]), 32'd0);
`endif

        // Randomised traffic, checked cycle-by-cycle against the model.
        for (int t = 0; t < 250; t++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 55) begin
                wr(BASE, $urandom, ($urandom_range(0, 4) == 0) ? 4'($urandom) : (4'($urandom) | 4'b0001));
            end else if (r < 70) begin
                wr(BASE + 32'h4, $urandom, 4'($urandom));
            end else if (r < 80) begin
                case ($urandom_range(0, 3))
                    0:       wr(BASE + 32'h8, $urandom, 4'($urandom));
                    1:       wr(BASE + 32'hC, $urandom, 4'($urandom));
                    2:       wr(BASE + 32'h10, $urandom, 4'b0001);
                    default: wr(BASE - 32'h10, $urandom, 4'b0001);
                endcase
            end else if (r < 92) begin
                memory_address = ($urandom_range(0, 1) == 0) ? (BASE | (32'($urandom_range(0, 3)) << 2)) : $urandom;
                idle($urandom_range(1, 30));
            end else begin
                idle(FL * $urandom_range(1, 4));
            end
        end
        wait_idle(2 * D * FL + 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
